// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock-generation control blocks.
//   pll_ctrl_state_t : sequencer states of pll_lock_ctrl
//   LOSS_CNT_W       : width of the lock-loss event counter
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_ctrl_state_t;

    localparam int unsigned LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level/status inputs.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears both stages to 0
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL start-up sequencer on the 25 MHz reference clock. Pulses the PLL
// reset, waits for a qualified lock with a timeout and bounded retries,
// and holds the downstream reset until lock has been stable long enough.
// Ports:
//   clk_25m       : reference clock, the only clock
//   rst_n         : synchronous active-low reset
//   pll_lock      : PLL lock, asynchronous (synchronised internally)
//   restart       : synchronous pulse forcing a full PLL restart
//   pll_rst       : PLL reset, active-high (PLL_RST and FAIL states)
//   sys_rst       : downstream reset request, active-high (not RUN)
//   clk_ok        : high only in RUN
//   fail          : high only in FAIL
//   retry_cnt     : retries consumed since last RUN entry or reset
//   lock_loss_cnt : saturating count of lock losses in RUN
// Optional feature: define PLL_LOCK_CTRL_LOSS_CNT_EN to build the
// lock-loss counter; otherwise lock_loss_cnt is tied to 0.
module pll_lock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned MAX_RETRIES        = 7
) (
    input  logic                               clk_25m,
    input  logic                               rst_n,
    input  logic                               pll_lock,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               clk_ok,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOSS_CNT_W-1:0]              lock_loss_cnt
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES);

    pll_ctrl_state_t  state;
    pll_ctrl_state_t  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             retry_inc;
    logic             retry_clr;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk_25m),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            state <= PLL_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        pll_rst   = 1'b0;
        sys_rst   = 1'b1;
        clk_ok    = 1'b0;
        fail      = 1'b0;

        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout expiring on the same edge.
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TMO_LAST) begin
                    if (retry_cnt == RTY_LAST) begin
                        state_nxt = FAIL;
                    end else begin
                        retry_inc = 1'b1;
                        state_nxt = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    state_nxt = RUN;
                    retry_clr = 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = PLL_RST;
            end
        endcase

        if (restart) begin
            state_nxt = PLL_RST;
            retry_inc = 1'b0;
            retry_clr = 1'b1;
        end

        pll_rst = (state == PLL_RST) || (state == FAIL);
        sys_rst = (state != RUN);
        clk_ok  = (state == RUN);
        fail    = (state == FAIL);
    end

    // A restart re-enters PLL_RST even from PLL_RST, so it also clears cnt.
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (state_nxt != state)) begin
            cnt <= '0;
        end else if ((state != RUN) && (state != FAIL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_q;

    assign loss_evt = (state == RUN) && !lock_s && !restart;

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != '1)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed scenarios followed by
// randomized lock/restart/reset stimulus, all checked every cycle against
// a deadline-based behavioural model.
module tb_pll_lock_ctrl;

    localparam int unsigned RST_C = 4;
    localparam int unsigned STB_C = 8;
    localparam int unsigned TMO_C = 32;
    localparam int unsigned MAX_R = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       clk_25m = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       clk_ok;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state
    int ph      = P_RST;
    int due     = 0;
    int retries = 0;
    int losses  = 0;
    bit lq0     = 1'b0;   // pll_lock sampled one edge ago
    bit lq1     = 1'b0;   // pll_lock sampled two edges ago

    pll_lock_ctrl #(
        .PLL_RST_CYCLES     (RST_C),
        .LOCK_STABLE_CYCLES (STB_C),
        .LOCK_TIMEOUT       (TMO_C),
        .MAX_RETRIES        (MAX_R)
    ) dut (
        .clk_25m       (clk_25m),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .clk_ok        (clk_ok),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            P_RST:   return RST_C;
            P_WAIT:  return TMO_C;
            P_STB:   return STB_C;
            default: return 0;
        endcase
    endfunction

    task automatic enter(input int p);
        ph  = p;
        due = cyc + dur(p);
    endtask

    // One clock edge of the reference behaviour, using the inputs present at it.
    task automatic model_step();
        bit lk;
        lk = lq1;
        if (!rst_n) begin
            enter(P_RST);
            retries = 0;
            losses  = 0;
            lq0     = 1'b0;
            lq1     = 1'b0;
            return;
        end
        lq1 = lq0;
        lq0 = pll_lock;
        if (restart) begin
            enter(P_RST);
            retries = 0;
        end else begin
            case (ph)
                P_RST:  if (cyc == due) enter(P_WAIT);
                P_WAIT: begin
                    if (lk) enter(P_STB);
                    else if (cyc == due) begin
                        if (retries == MAX_R) enter(P_FAIL);
                        else begin
                            retries++;
                            enter(P_RST);
                        end
                    end
                end
                P_STB: begin
                    if (!lk) enter(P_WAIT);
                    else if (cyc == due) begin
                        enter(P_RUN);
                        retries = 0;
                    end
                end
                P_RUN: begin
                    if (!lk) begin
                        enter(P_RST);
                        if (losses < 255) losses++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        int unsigned exp_loss;
        @(posedge clk_25m);
        cyc++;
        model_step();
        #1;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
        exp_loss = losses;
`else
        exp_loss = 0;
`endif
        check("pll_rst",       pll_rst,       (ph == P_RST) || (ph == P_FAIL));
        check("sys_rst",       sys_rst,       ph != P_RUN);
        check("clk_ok",        clk_ok,        ph == P_RUN);
        check("fail",          fail,          ph == P_FAIL);
        check("retry_cnt",     retry_cnt,     retries);
        check("lock_loss_cnt", lock_loss_cnt, exp_loss);
    endtask

    initial begin
        int k;
        int j;
        int guard;

        rst_n    = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // clean start-up
        repeat (10) tick();
        pll_lock = 1'b1;
        tick();
        k = cyc;
        guard = 0;
        while (sys_rst && guard < 40) begin
            tick();
            guard++;
        end
        check("startup_latency", cyc - k, 10);

        // lock loss in RUN
        repeat (3) tick();
        pll_lock = 1'b0;
        tick();
        j = cyc;
        tick();
        check("loss_sys_rst_j1", sys_rst, 0);
        tick();
        check("loss_sys_rst_j2", sys_rst, 1);
        check("loss_pll_rst_j2", pll_rst, 1);

        // lock stays low: three timeouts then FAIL
        guard = 0;
        while (!fail && guard < 200) begin
            tick();
            guard++;
        end
        check("fail_latency", cyc - j, 2 + 3 * (RST_C + TMO_C));
        repeat (10) tick();

        // restart out of FAIL
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_fail_pll_rst", pll_rst, 1);
        check("restart_fail_retry", retry_cnt, 0);

        // glitch during STABLE
        repeat (6) tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        k = cyc;
        guard = 0;
        while (sys_rst && guard < 40) begin
            tick();
            guard++;
        end
        check("glitch_latency", cyc - k, 10);

        // restart in RUN
        repeat (3) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_run_sys_rst", sys_rst, 1);

        // reset while in STABLE
        guard = 0;
        while (ph != P_STB && guard < 40) begin
            tick();
            guard++;
        end
        check("reach_stable", ph, P_STB);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_loss_cnt", lock_loss_cnt, 0);
        check("midrst_pll_rst", pll_rst, 1);

        // randomized segments
        for (int s = 0; s < 160; s++) begin
            int unsigned kind;
            int unsigned len;
            kind = $urandom_range(0, 11);
            case (kind)
                0: begin
                    len = $urandom_range(4, 30);
                    repeat (len) begin
                        pll_lock = ~pll_lock;
                        tick();
                    end
                end
                1: begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end
                2: begin
                    restart = 1'b1;
                    tick();
                    restart = 1'b0;
                end
                3, 4, 5, 6: begin
                    len = $urandom_range(1, 40);
                    pll_lock = 1'b1;
                    repeat (len) tick();
                end
                7, 8: begin
                    len = $urandom_range(1, 120);
                    pll_lock = 1'b0;
                    repeat (len) tick();
                end
                default: begin
                    len = $urandom_range(1, 20);
                    repeat (len) begin
                        pll_lock = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Sequencer for the board PLL that generates the TMDS and pixel clocks. It runs on the 25 MHz reference clock and drives the PLL reset. It qualifies the asynchronous PLL lock indication, retries PLL start-up with a timeout, and holds the downstream fabric reset until lock has been stable for a programmable time. It sits between the clock-generation wrapper and the video pipeline's reset synchronisers.

## Interface
Parameters:
- PLL_RST_CYCLES, default 16: cycles `pll_rst` is held high per PLL reset pulse; minimum 1.
- LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before release; minimum 1.
- LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry; minimum 2.
- MAX_RETRIES, default 7: retries permitted before FAIL.

Ports (synchronous, active-low reset):
- `clk_25m` in, 1: 25 MHz reference clock; the only clock.
- `rst_n` in, 1: synchronous, active-low reset.
- `pll_lock` in, 1: PLL LOCK, asynchronous to `clk_25m`.
- `restart` in, 1: synchronous pulse forcing a full PLL restart.
- `pll_rst` out, 1: PLL RST, active-high.
- `sys_rst` out, 1: active-high downstream reset request; consumers resynchronise it per domain.
- `clk_ok` out, 1: high only in RUN.
- `fail` out, 1: high only in FAIL.
- `retry_cnt` out, $clog2(MAX_RETRIES+1): retries consumed since the last RUN entry or reset.
- `lock_loss_cnt` out, 8: lock-loss events while in RUN; tied 0 unless the macro is defined.

## Operation
- `pll_lock` passes through a 2-flop synchroniser to produce `lock_s`. No other logic reads `pll_lock` directly.
- One shared cycle counter `cnt`, width $clog2 of the largest count parameter. It clears on every state entry.
- States and transitions:
  - **PLL_RST**: `cnt` increments. When `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK.
  - **WAIT_LOCK**: if `lock_s` is high, go to STABLE. Otherwise, when `cnt == LOCK_TIMEOUT-1`:
    - if `retry_cnt == MAX_RETRIES`, go to FAIL;
    - else `retry_cnt` increments and the state goes to PLL_RST.
  - **STABLE**: if `lock_s` is low, go to WAIT_LOCK. No retry is consumed, and the timeout restarts from 0. When `cnt == LOCK_STABLE_CYCLES-1` with `lock_s` high, go to RUN.
  - **RUN**: `retry_cnt` clears on entry. If `lock_s` goes low, go to PLL_RST; this counts as one lock-loss event.
  - **FAIL**: terminal; exited only by `rst_n` or `restart`.
- `restart` is high: from any state, next state is PLL_RST and `retry_cnt` clears. `restart` has priority over all other transitions and is not counted as a lock loss.
- Moore outputs, decoded from the registered state:
  - `pll_rst` = PLL_RST or FAIL
  - `sys_rst` = not RUN
  - `clk_ok` = RUN
  - `fail` = FAIL
- `cnt` never wraps. Every state exits at or before its terminal count.

## Timing
- Reset (`rst_n` low at an edge) sets:
  - state = PLL_RST, `cnt` = 0, synchroniser = 0, `retry_cnt` = 0, `lock_loss_cnt` = 0
  - outputs: `pll_rst` = 1, `sys_rst` = 1, `clk_ok` = 0, `fail` = 0
- Reset mid-operation (any state, including RUN) behaves identically; outputs reach these values at the same edge.
- After reset, `pll_rst` is high for exactly PLL_RST_CYCLES cycles.
- Lock acquisition: `pll_lock` is first sampled high at edge k.
  - STABLE is entered at edge k+2.
  - RUN is entered, and `sys_rst` falls, at edge k+2+LOCK_STABLE_CYCLES.
- Lock loss in RUN: `pll_lock` is first sampled low at edge j. At edge j+2, state = PLL_RST, so `sys_rst` = 1 and `pll_rst` = 1.
- Lock toggling every cycle never reaches RUN.
- If `lock_s` rises on the same edge the WAIT_LOCK timeout expires, the lock wins and the state goes to STABLE.

## Configuration
- `PLL_LOCK_CTRL_LOSS_CNT_EN` defined:
  - `lock_loss_cnt` increments on each RUN→PLL_RST transition caused by lock loss.
  - It saturates at 255 and clears only on `rst_n`.
- Undefined: `lock_loss_cnt` is constant 0 and no counter register is built.

## Structure
- Package `clock_ctrl_pkg` holds:
  - state enum `pll_ctrl_state_t` {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL}
  - the constant `LOSS_CNT_W` = 8.
- Sub-module `sync_2ff`: the 2-flop synchroniser, reset to 0 by `rst_n`, reusable for other asynchronous status inputs.

## Test plan
Parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
- **Clean start-up**: release reset, raise `pll_lock` at cycle 10 → `pll_rst` high for cycles 0–3; `sys_rst` falls exactly 10 edges after lock is first sampled; `clk_ok` = 1; `retry_cnt` = 0.
- **Timeout and fail**: hold `pll_lock` = 0 → `pll_rst` pulses 4 cycles each time; `retry_cnt` steps 1, 2; after the third timeout, `fail` = 1 and `pll_rst` stays 1 permanently.
- **Glitch during STABLE**: lock high 5 cycles, low 1 cycle, then high → no retry consumed; `sys_rst` falls 10 edges after the second rising sample.
- **Lock loss in RUN**: drop `pll_lock` → `sys_rst` = 1 and `pll_rst` = 1 two edges later; `lock_loss_cnt` = 1 with the macro, 0 without.
- **Restart**: pulse `restart` in RUN and in FAIL → both reach PLL_RST next edge; `retry_cnt` = 0; `lock_loss_cnt` unchanged.
- **Mid-operation reset**: `rst_n` low during STABLE → all outputs take their reset values at that edge; `lock_loss_cnt` = 0.
